// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the instruction/data SRAM port arbiter:
// read-return state encoding and default geometry constants.
package mem_port_arbiter_pkg;

  // Which requester, if any, owns the SRAM read data arriving this cycle
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RET_I = 2'd1,
    RET_D = 2'd2
  } ret_state_e;

  localparam int DEF_AW   = 10;
  localparam int DEF_BW   = 32;
  localparam int DEF_MAXD = 4;

  // Requesters always present full word addresses of this width
  localparam int REQ_AW = 30;

endpackage

// File: rtl/mem_arb_prio.sv
// Combinational grant decision between fetch and data requesters.
// Data normally wins; once the data side has been granted MAXD times in a
// row while fetch waited, fetch is given the port for one cycle.
module mem_arb_prio #(
  parameter int MAXD = 4,
  parameter int CW   = 3
) (
  input  logic          rst,
  input  logic          ireq,
  input  logic          dreq,
  input  logic [CW-1:0] starve_cnt,
  output logic          ignt,
  output logic          dgnt
);

  localparam logic [CW-1:0] MAXD_C = CW'(MAXD);

  logic starved;

  // Pick at most one winner; nothing is granted while reset is held
  always_comb begin
    starved = (starve_cnt == MAXD_C);
    ignt    = 1'b0;
    dgnt    = 1'b0;
    if (!rst) begin
      if (ireq && (!dreq || starved)) begin
        ignt = 1'b1;
      end else if (dreq) begin
        dgnt = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port SRAM shared between an instruction fetch port and a data
// port. Grants issue the SRAM access in the same cycle; read data comes
// back one cycle later and is steered to whichever side issued the read.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW   = DEF_AW,
  parameter int BW   = DEF_BW,
  parameter int MAXD = DEF_MAXD
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IREQ,
  input  logic [REQ_AW-1:0] IADDR,
  output logic              IGNT,
  output logic              IVALID,
  output logic [BW-1:0]     INSTR,
  input  logic              DREQ,
  input  logic              DRW,
  input  logic [REQ_AW-1:0] DADDR,
  input  logic [BW-1:0]     DWDATA,
  output logic              DGNT,
  output logic              DVALID,
  output logic [BW-1:0]     DRDATA,
  output logic              CSN,
  output logic              WEN,
  output logic [AW-1:0]     A,
  output logic [BW-1:0]     DI,
  input  logic [BW-1:0]     DOUT
);

  localparam int CW = $clog2(MAXD + 1);
  localparam logic [CW-1:0] MAXD_C = CW'(MAXD);

  ret_state_e    state;
  ret_state_e    state_next;
  logic [CW-1:0] starve_cnt;
  logic          ignt;
  logic          dgnt;
  logic          unused_addr_bits;

  // Word addresses wider than the SRAM simply alias; the extra bits are dropped
  assign unused_addr_bits = ^{IADDR[REQ_AW-1:AW], DADDR[REQ_AW-1:AW]};

  mem_arb_prio #(
    .MAXD (MAXD),
    .CW   (CW)
  ) u_prio (
    .rst        (RST),
    .ireq       (IREQ),
    .dreq       (DREQ),
    .starve_cnt (starve_cnt),
    .ignt       (ignt),
    .dgnt       (dgnt)
  );

  assign IGNT = ignt;
  assign DGNT = dgnt;

  // Count consecutive data wins that left a fetch waiting, capped at MAXD
  always_ff @(posedge CLK) begin
    if (RST) begin
      starve_cnt <= '0;
    end else if (ignt || !IREQ) begin
      starve_cnt <= '0;
    end else if (dgnt && (starve_cnt != MAXD_C)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Read-return state register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Remember who issued a read this cycle so next cycle's SRAM data goes there
  always_comb begin
    state_next = IDLE;
    if (ignt) begin
      state_next = RET_I;
    end else if (dgnt && !DRW) begin
      state_next = RET_D;
    end
  end

  // Steer SRAM read data to its owner; outputs stay zero otherwise and during reset
  always_comb begin
    IVALID = 1'b0;
    INSTR  = '0;
    DVALID = 1'b0;
    DRDATA = '0;
    if (!RST) begin
      if (state == RET_I) begin
        IVALID = 1'b1;
        INSTR  = DOUT;
      end else if (state == RET_D) begin
        DVALID = 1'b1;
        DRDATA = DOUT;
      end
    end
  end

  // Drive the SRAM pins from whichever side won this cycle
  always_comb begin
    CSN = 1'b1;
    WEN = 1'b1;
    A   = '0;
    DI  = '0;
    if (ignt) begin
      CSN = 1'b0;
      A   = IADDR[AW-1:0];
    end else if (dgnt) begin
      CSN = 1'b0;
      A   = DADDR[AW-1:0];
      if (DRW) begin
        WEN = 1'b0;
        DI  = DWDATA;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 1-cycle SRAM.
module tb_mem_port_arbiter;

  localparam logic [31:0] I_VAL = 32'h1111_AAAA;
  localparam logic [31:0] D_VAL = 32'h2222_BBBB;

  logic        CLK = 1'b0;
  logic        RST;
  logic        IREQ;
  logic [29:0] IADDR;
  logic        IGNT;
  logic        IVALID;
  logic [31:0] INSTR;
  logic        DREQ;
  logic        DRW;
  logic [29:0] DADDR;
  logic [31:0] DWDATA;
  logic        DGNT;
  logic        DVALID;
  logic [31:0] DRDATA;
  logic        CSN;
  logic        WEN;
  logic [9:0]  A;
  logic [31:0] DI;
  logic [31:0] DOUT;

  logic [31:0] mem [0:1023];

  int vectors = 0;
  int miscompares = 0;

  mem_port_arbiter dut (
    .CLK    (CLK),
    .RST    (RST),
    .IREQ   (IREQ),
    .IADDR  (IADDR),
    .IGNT   (IGNT),
    .IVALID (IVALID),
    .INSTR  (INSTR),
    .DREQ   (DREQ),
    .DRW    (DRW),
    .DADDR  (DADDR),
    .DWDATA (DWDATA),
    .DGNT   (DGNT),
    .DVALID (DVALID),
    .DRDATA (DRDATA),
    .CSN    (CSN),
    .WEN    (WEN),
    .A      (A),
    .DI     (DI),
    .DOUT   (DOUT)
  );

  always #5 CLK = ~CLK;

  // Registered-output SRAM: write takes effect at the edge, read data appears after it
  always @(posedge CLK) begin
    if (!CSN) begin
      if (!WEN) mem[A] <= DI;
      DOUT <= mem[A];
    end
  end

  task automatic idle_inputs();
    IREQ = 1'b0; IADDR = '0; DREQ = 1'b0; DRW = 1'b0; DADDR = '0; DWDATA = '0;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    IREQ = 1'b1; IADDR = 30'd10; DREQ = 1'b1; DADDR = 30'd20;
    #1;
    vectors++;
    if ({IGNT, DGNT, CSN, WEN} !== 4'b0011) begin
      miscompares++;
      $display("[TB] FAIL reset_gating: got IGNT,DGNT,CSN,WEN=%b expected 0011", {IGNT, DGNT, CSN, WEN});
    end
    vectors++;
    if ({A, DI, IVALID, DVALID, INSTR, DRDATA} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got A=%h DI=%h IV=%b DV=%b INSTR=%h DRDATA=%h expected all zero", A, DI, IVALID, DVALID, INSTR, DRDATA);
    end
    @(negedge CLK);
    RST = 1'b0; idle_inputs();
    #1;
    vectors++;
    if ({IGNT, DGNT, CSN, WEN, IVALID, DVALID} !== 6'b001100 || A !== 10'd0 || INSTR !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL post_reset_idle: got IGNT,DGNT,CSN,WEN,IV,DV=%b A=%h INSTR=%h expected 001100 A=0 INSTR=0", {IGNT, DGNT, CSN, WEN, IVALID, DVALID}, A, INSTR);
    end
  endtask

  task automatic test_fetch();
    @(negedge CLK);
    IREQ = 1'b1; IADDR = {20'hABCDE, 10'd5};
    #1;
    vectors++;
    if ({IGNT, DGNT, CSN, WEN} !== 4'b1001) begin
      miscompares++;
      $display("[TB] FAIL fetch_grant: got IGNT,DGNT,CSN,WEN=%b expected 1001", {IGNT, DGNT, CSN, WEN});
    end
    vectors++;
    if (A !== 10'd5) begin
      miscompares++;
      $display("[TB] FAIL fetch_addr_alias: got A=%0d expected 5", A);
    end
    @(negedge CLK);
    idle_inputs();
    #1;
    vectors++;
    if (IVALID !== 1'b1 || INSTR !== 32'h1234_5678 || DVALID !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL fetch_return: got IV=%b INSTR=%h DV=%b expected IV=1 INSTR=12345678 DV=0", IVALID, INSTR, DVALID);
    end
    @(negedge CLK);
    #1;
    vectors++;
    if (IVALID !== 1'b0 || INSTR !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL fetch_return_drop: got IV=%b INSTR=%h expected 0 and 0", IVALID, INSTR);
    end
  endtask

  task automatic test_write_read();
    @(negedge CLK);
    DREQ = 1'b1; DRW = 1'b1; DADDR = 30'd3; DWDATA = 32'hDEAD_BEEF;
    #1;
    vectors++;
    if ({IGNT, DGNT, CSN, WEN} !== 4'b0100 || A !== 10'd3 || DI !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("[TB] FAIL write_issue: got IGNT,DGNT,CSN,WEN=%b A=%0d DI=%h expected 0100 A=3 DI=deadbeef", {IGNT, DGNT, CSN, WEN}, A, DI);
    end
    @(negedge CLK);
    DRW = 1'b0; DWDATA = 32'h5555_5555;
    #1;
    vectors++;
    if ({DGNT, CSN, WEN, DVALID} !== 4'b1010 || DI !== 32'd0 || DRDATA !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL read_issue: got DGNT,CSN,WEN,DV=%b DI=%h DRDATA=%h expected 1010 DI=0 DRDATA=0", {DGNT, CSN, WEN, DVALID}, DI, DRDATA);
    end
    @(negedge CLK);
    idle_inputs();
    #1;
    vectors++;
    if (DVALID !== 1'b1 || DRDATA !== 32'hDEAD_BEEF || IVALID !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL read_after_write: got DV=%b DRDATA=%h IV=%b expected DV=1 DRDATA=deadbeef IV=0", DVALID, DRDATA, IVALID);
    end
    vectors++;
    if ({CSN, WEN} !== 2'b11 || A !== 10'd0) begin
      miscompares++;
      $display("[TB] FAIL no_request_pins: got CSN,WEN=%b A=%h expected 11 A=0", {CSN, WEN}, A);
    end
  endtask

  task automatic test_starvation();
    logic exp_i;
    logic prev_i;
    prev_i = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      IREQ = 1'b1; IADDR = 30'd10; DREQ = 1'b1; DRW = 1'b0; DADDR = 30'd20;
      #1;
      exp_i = ((k % 5) == 4);
      vectors++;
      if ({IGNT, DGNT} !== {exp_i, ~exp_i} || A !== (exp_i ? 10'd10 : 10'd20)) begin
        miscompares++;
        $display("[TB] FAIL starve_grant[%0d]: got IGNT,DGNT=%b A=%0d expected %b", k, {IGNT, DGNT}, A, {exp_i, ~exp_i});
      end
      if (k > 0) begin
        vectors++;
        if ({IVALID, DVALID} !== {prev_i, ~prev_i} || (prev_i ? INSTR : DRDATA) !== (prev_i ? I_VAL : D_VAL)) begin
          miscompares++;
          $display("[TB] FAIL starve_return[%0d]: got IV,DV=%b INSTR=%h DRDATA=%h expected IV,DV=%b", k, {IVALID, DVALID}, INSTR, DRDATA, {prev_i, ~prev_i});
        end
      end
      prev_i = exp_i;
    end
    @(negedge CLK);
    idle_inputs();
    #1;
    vectors++;
    if ({IVALID, DVALID} !== 2'b10 || INSTR !== I_VAL) begin
      miscompares++;
      $display("[TB] FAIL starve_last_return: got IV,DV=%b INSTR=%h expected 10 INSTR=%h", {IVALID, DVALID}, INSTR, I_VAL);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_prev;
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      idle_inputs();
      if (k % 2 == 0) begin
        IREQ = 1'b1; IADDR = 30'(30 + k);
      end else begin
        DREQ = 1'b1; DADDR = 30'(30 + k);
      end
      #1;
      vectors++;
      if ({IGNT, DGNT} !== ((k % 2 == 0) ? 2'b10 : 2'b01) || A !== 10'(30 + k)) begin
        miscompares++;
        $display("[TB] FAIL alt_grant[%0d]: got IGNT,DGNT=%b A=%0d expected A=%0d", k, {IGNT, DGNT}, A, 30 + k);
      end
      if (k > 0) begin
        exp_prev = 32'hA000_0000 + 32'(k - 1);
        vectors++;
        if ((k % 2 == 1) ? (IVALID !== 1'b1 || DVALID !== 1'b0 || INSTR !== exp_prev)
                         : (DVALID !== 1'b1 || IVALID !== 1'b0 || DRDATA !== exp_prev)) begin
          miscompares++;
          $display("[TB] FAIL alt_return[%0d]: got IV=%b DV=%b INSTR=%h DRDATA=%h expected data %h", k, IVALID, DVALID, INSTR, DRDATA, exp_prev);
        end
      end
    end
    @(negedge CLK);
    idle_inputs();
    #1;
    vectors++;
    if (DVALID !== 1'b1 || DRDATA !== 32'hA000_0007) begin
      miscompares++;
      $display("[TB] FAIL alt_last_return: got DV=%b DRDATA=%h expected 1 a0000007", DVALID, DRDATA);
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      IREQ = 1'b1; IADDR = 30'd10; DREQ = 1'b1; DRW = 1'b0; DADDR = 30'd20;
      #1;
      vectors++;
      if ({IGNT, DGNT} !== 2'b01) begin
        miscompares++;
        $display("[TB] FAIL midrst_pre_grant[%0d]: got IGNT,DGNT=%b expected 01", k, {IGNT, DGNT});
      end
    end
    @(negedge CLK);
    RST = 1'b1;
    #1;
    vectors++;
    if ({IGNT, DGNT, CSN, DVALID, IVALID} !== 5'b00100 || DRDATA !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL midrst_drop: got IGNT,DGNT,CSN,DV,IV=%b DRDATA=%h expected 00100 DRDATA=0", {IGNT, DGNT, CSN, DVALID, IVALID}, DRDATA);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      RST = 1'b0;
      #1;
      if (k == 0) begin
        vectors++;
        if ({DVALID, IVALID} !== 2'b00) begin
          miscompares++;
          $display("[TB] FAIL midrst_no_valid: got DV,IV=%b expected 00", {DVALID, IVALID});
        end
      end
      vectors++;
      if ({IGNT, DGNT} !== ((k == 4) ? 2'b10 : 2'b01)) begin
        miscompares++;
        $display("[TB] FAIL midrst_counter_cleared[%0d]: got IGNT,DGNT=%b expected %b", k, {IGNT, DGNT}, (k == 4) ? 2'b10 : 2'b01);
      end
    end
    @(negedge CLK);
    idle_inputs();
  endtask

  task automatic test_vanish();
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      IREQ = 1'b1; IADDR = 30'd10; DREQ = 1'b1; DRW = 1'b0; DADDR = 30'd20;
    end
    @(negedge CLK);
    DRW = 1'b1; DADDR = 30'd7; DWDATA = 32'hBAD0_BAD0;
    #1;
    vectors++;
    if ({IGNT, DGNT, WEN} !== 3'b101 || DI !== 32'd0 || A !== 10'd10) begin
      miscompares++;
      $display("[TB] FAIL vanish_lose: got IGNT,DGNT,WEN=%b DI=%h A=%0d expected 101 DI=0 A=10", {IGNT, DGNT, WEN}, DI, A);
    end
    @(negedge CLK);
    idle_inputs();
    #1;
    vectors++;
    if ({DGNT, CSN, WEN} !== 3'b011) begin
      miscompares++;
      $display("[TB] FAIL vanish_gone: got DGNT,CSN,WEN=%b expected 011", {DGNT, CSN, WEN});
    end
    @(negedge CLK);
    vectors++;
    if (mem[7] !== 32'h0707_0707) begin
      miscompares++;
      $display("[TB] FAIL vanish_no_write: got mem[7]=%h expected 07070707", mem[7]);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    mem[5]  = 32'h1234_5678;
    mem[7]  = 32'h0707_0707;
    mem[10] = I_VAL;
    mem[20] = D_VAL;
    for (int i = 0; i < 8; i++) mem[30 + i] = 32'hA000_0000 + 32'(i);
    DOUT = 32'd0;
    RST = 1'b1;
    idle_inputs();
    repeat (2) @(posedge CLK);

    test_reset();
    test_fetch();
    test_write_read();
    test_starvation();
    test_back_to_back();
    test_reset_mid();
    test_vanish();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
